// File: rtl/hex_shift_display.sv
// hex_shift_display: shifts a byte out as two common-anode 7-segment digits to a cascaded 74HC595 pair
module hex_shift_display #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       update,
    output logic       ser,
    output logic       sclk,
    output logic       rclk,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
    localparam logic [15:0][7:0] SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
    localparam logic [7:0] LAST = 8'(DIV - 1);
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, hold_q, hold_d, start;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] frame_q, frame_d, enc;
    logic        pending_q, pending_d, upd_prev_q, rise, phase_end;
    logic        ser_q, ser_d, sclk_q, sclk_d, rclk_q, rclk_d, busy_q, busy_d, done_q, done_d;

    assign rise      = update & ~upd_prev_q;
    assign phase_end = cnt_q == LAST;
    assign start     = rise ? data : hold_q;
    assign enc       = {SEG[start[7:4]], SEG[start[3:0]]};
    assign ser       = ser_q;
    assign sclk      = sclk_q;
    assign rclk      = rclk_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state logic: frame sequencing, bit/phase counting and latching of edges that arrive mid-frame
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        ser_d     = ser_q;
        case (state_q)
            IDLE: if (rise || pending_q) begin
                frame_d   = enc;
                ser_d     = enc[15];
                pending_d = 1'b0;
                state_d   = LOAD;
            end
            LOAD: begin
                bit_d   = 4'd15;
                cnt_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                cnt_d   = phase_end ? 8'd0 : cnt_q + 8'd1;
                state_d = phase_end ? SHIFT_HI : SHIFT_LO;
            end
            SHIFT_HI: begin
                cnt_d = phase_end ? 8'd0 : cnt_q + 8'd1;
                if (phase_end && bit_q == 4'd0) begin
                    state_d = LATCH;
                end else if (phase_end) begin
                    bit_d   = bit_q - 4'd1;
                    ser_d   = frame_q[bit_q - 4'd1];
                    state_d = SHIFT_LO;
                end
            end
            LATCH: begin
                cnt_d   = phase_end ? 8'd0 : cnt_q + 8'd1;
                state_d = phase_end ? DONE : LATCH;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rise && state_q != IDLE) begin
            pending_d = 1'b1;
            hold_d    = data;
        end
        sclk_d = state_d == SHIFT_HI;
        rclk_d = state_d == LATCH;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    // State and registered outputs; reset drops everything to idle without touching the 595 latch
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            hold_q     <= '0;
            pending_q  <= 1'b0;
            upd_prev_q <= 1'b1;
            ser_q      <= 1'b0;
            sclk_q     <= 1'b0;
            rclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            upd_prev_q <= update;
            ser_q      <= ser_d;
            sclk_q     <= sclk_d;
            rclk_q     <= rclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: doc/hex_shift_display.md
HEX_SHIFT_DISPLAY -- requirements
Module: hex_shift_display

Interface
REQ-001 Parameter DIV, default 4: clk cycles per sclk half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 data  input  8  byte to display; [7:4] is the high digit, [3:0] is the low digit.
REQ-005 update  input  1  request from the upstream setter; held high for several cycles; only its rising edge matters.
REQ-006 ser  output  1  serial data to the cascaded 74HC595 pair.
REQ-007 sclk  output  1  shift clock to the 595s; the 595 samples ser on sclk rising edge.
REQ-008 rclk  output  1  storage-register latch to the 595s; outputs update on its rising edge.
REQ-009 busy  output  1  high from frame load until the latch completes.
REQ-010 done  output  1  one-cycle pulse when a frame has been latched.

Function
REQ-011 The block SHALL detect an update rising edge by comparing update with its registered value; updPrev resets to 1.
REQ-012 The block SHALL encode each nibble as a common-anode 7-segment pattern, bit order {dp,g,f,e,d,c,b,a}, active-low, dp off.
REQ-013 The encoding for nibbles 0..F SHALL be C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (hex).
REQ-014 The frame SHALL be {seg(data[7:4]), seg(data[3:0])}, 16 bits, shifted MSB (bit 15) first.
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-016 IDLE: on a rising edge or when pending is set, the FSM SHALL capture the frame from the current data and move to LOAD.
REQ-017 LOAD (1 cycle): the FSM SHALL drive ser = frame[15], set bit counter = 15, and go to SHIFT_LO.
REQ-018 SHIFT_LO: sclk is 0 for DIV cycles, then the FSM goes to SHIFT_HI.
REQ-019 SHIFT_HI: sclk is 1 for DIV cycles. Then, if counter = 0, the FSM goes to LATCH; otherwise it decrements the counter, drives ser with the next lower bit, and goes to SHIFT_LO.
REQ-020 ser SHALL change only on the cycle sclk falls, or in LOAD; it is stable for the whole sclk-high phase.
REQ-021 LATCH: sclk = 0 and rclk = 1 for DIV cycles, then the FSM goes to DONE.
REQ-022 DONE (1 cycle): done = 1, rclk = 0, then the FSM goes to IDLE.
REQ-023 busy SHALL be 1 in LOAD, SHIFT_LO, SHIFT_HI, LATCH and DONE, and 0 in IDLE.
REQ-024 Frame duration from the LOAD cycle to the DONE cycle inclusive SHALL be 32*DIV + DIV + 2 cycles.
REQ-025 A rising edge while busy SHALL set pending and capture data into a holding register, latest edge wins.
REQ-026 The frame in flight SHALL NOT be altered by a rising edge while busy.
REQ-027 In IDLE with pending set, the FSM SHALL clear pending and start from the holding register on the next cycle.
REQ-028 data changes without an update edge SHALL have no effect.
REQ-029 A rising edge in the DONE cycle SHALL be treated as pending: exactly one further frame follows.
REQ-030 Counter widths: the phase counter is 8 bits and the bit counter is 4 bits; neither SHALL wrap outside its defined range.

Reset
REQ-031 While reset = 0, state = IDLE and ser = 0, sclk = 0, rclk = 0, busy = 0, done = 0, pending = 0, updPrev = 1, frame = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame on the next clk edge without pulsing rclk; the 595 outputs keep the previous frame.
REQ-033 After reset release, no frame SHALL start until an update rising edge occurs.

Verification
REQ-034 DIV = 4, data = 8'h3A, update pulse of 8 cycles -> 16 sclk rising edges with ser = B0 then 88 (MSB first), 16'hB088; one rclk pulse 4 cycles wide; done once; busy high for 134 cycles.
REQ-035 data = 8'hFF, then update -> captured frame 16'h8E8E; data = 8'h00 -> frame 16'hC0C0.
REQ-036 Second update edge at mid-frame with data = 8'h12 -> first frame completes unchanged, then frame 16'hF9A4 starts 1 cycle after DONE; exactly two rclk pulses in total.
REQ-037 reset = 0 during bit 7 of a frame -> the next cycle has all outputs at 0 and state IDLE; no rclk pulse; a new update afterwards yields a full correct frame.
REQ-038 update held high for 100 cycles -> exactly one frame; DIV = 1 -> frame lasts 35 cycles, with sclk period 2 cycles.
REQ-039 The bench SHALL model a 74HC595 pair and check that the latched 16 bits equal the expected frame after every done pulse.
